mfp_ahb_gpio_irq: RTL and testbench
===================================

// Module: mfp_ahb_gpio_irq
// PURPOSE
//  Parametrised AHB-Lite GPIO slave with atomic output set/clear/toggle and
//  per-bit edge-detect interrupts.
//  - Inputs: N_IN-bit 2-flop synchronizer, then edge detector feeding a
//    W1C status register.
//  - IRQ: single level interrupt, wired to the MIPSfpga interrupt controller.
//  - Sits on the AHB decoder alongside the RAM/7-seg slaves.
// PARAMETERS
//  N_IN      16   input pin count (1..32)
//  N_OUT     16   output pin count (1..32)
//  DB_CYCLES 4    debounce stable-cycle count (1..255), used only with GPIO_DEBOUNCE_EN
// PORTS
//  HCLK        in   1      bus/system clock; all logic on rising edge
//  HRESET      in   1      synchronous active-high reset
//  HADDR       in   6      byte address; register index = HADDR[5:2]
//  HTRANS      in   2      AHB transfer type
//  HWDATA      in   32     write data (data phase)
//  HWRITE      in   1      1 = write
//  HSEL        in   1      slave select
//  HRDATA      out  32     registered read data
//  GPIO_IN     in   N_IN   asynchronous input pins
//  GPIO_OUT    out  N_OUT  output pins (= OUT register)
//  IRQ         out  1      registered interrupt request, active high
// BEHAVIOUR
//  Clock and reset:
//  - One clock, HCLK. HRESET is synchronous, active high.
//  - HRESET clears all of the following to 0: OUT, RISE_EN, FALL_EN,
//    IRQ_STATUS, IRQ_MASK, synchronizers, edge history, HRDATA, IRQ.
//  - HRESET mid-transfer: the pending write is dropped.
//  Bus protocol:
//  - Zero wait states; no HREADYOUT or HRESP ports.
//  - Address-phase signals (HADDR, HWRITE, HSEL, HTRANS) are registered.
//  - Write takes effect at the edge ending the data phase when
//    HTRANS_d != IDLE, HSEL_d = 1 and HWRITE_d = 1.
//  - Read: HRDATA is loaded on the edge ending the address phase
//    (1-cycle latency). It is zero-extended and does not depend on
//    HSEL or HWRITE.
//  Register map (index = HADDR[5:2]):
//   0 IN          RO     synchronized (or debounced) inputs
//   1 OUT         RW
//   2 OUT_SET     WO     OUT |= wdata; reads 0
//   3 OUT_CLR     WO     OUT &= ~wdata; reads 0
//   4 OUT_TGL     WO     OUT ^= wdata; reads 0
//   5 RISE_EN     RW     per-bit rising-edge capture enable
//   6 FALL_EN     RW     per-bit falling-edge capture enable
//   7 IRQ_STATUS  R/W1C  sticky edge flags
//   8 IRQ_MASK    RW
//   9-15                 reads 0; writes ignored
//  - Write-data bits at or above N_IN / N_OUT are ignored.
//  Input path and edge detection:
//  - Pin change before edge k: sync stage 1 at k; IN readable after k+1;
//    prev stage updates at k+2.
//  - edge_r = IN & ~prev & RISE_EN; edge_f = ~IN & prev & FALL_EN.
//  - STATUS(next) = (STATUS & ~w1c) | edge_r | edge_f.
//    A new edge in the same cycle as a W1C of that bit leaves the bit set.
//  - Timing: STATUS sets at k+2. IRQ <= |(STATUS & IRQ_MASK) registers at k+3.
//  - Changing RISE_EN, FALL_EN or IRQ_MASK never clears STATUS.
//  - With IRQ_MASK = 0, STATUS still records edges (polled mode).
//  - A pulse shorter than one HCLK may be missed (no pulse stretching).
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined:
//  - Per input bit, an 8-bit counter sits between sync stage 2 and IN.
//  - Counter resets to 0 whenever sync2 == IN.
//  - IN bit flips when sync2 != IN has held for DB_CYCLES consecutive
//    cycles; counter then resets.
//  - Edge detection runs on the debounced IN; adds DB_CYCLES latency.
//  GPIO_DEBOUNCE_EN undefined:
//  - IN = sync stage 2. No counters are instantiated; DB_CYCLES is ignored.
// TESTING
//  T1 reset: assert HRESET for 2 cycles with GPIO_IN=16'hFFFF
//     -> GPIO_OUT=0, IRQ=0, read IRQ_STATUS=0.
//  T2 atomic output: OUT=16'h00F0; SET 16'h0003; CLR 16'h0010; TGL 16'h8000
//     -> GPIO_OUT=16'h80E3; read OUT=32'h000080E3; read OUT_SET=0.
//  T3 rising IRQ: RISE_EN=1, MASK=1, GPIO_IN[0] 0->1
//     -> STATUS=1 at k+2, IRQ=1 at k+3; W1C 1 -> IRQ=0 the following cycle.
//  T4 collision: FALL_EN=2; time W1C of bit1 in the same cycle as a new
//     fall on bit1 -> STATUS[1] stays 1.
//  T5 masking and holes: MASK=0 with an edge -> STATUS=1, IRQ=0;
//     then MASK=1 -> IRQ=1. Read index 12 -> 0.
//  T6 debounce (GPIO_DEBOUNCE_EN, DB_CYCLES=4): 3-cycle glitch -> no IN
//     change, STATUS=0; 6-cycle level -> IN updates and edge captured.

Source files
------------

// File: rtl/mfp_ahb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module     : mfp_ahb_gpio_irq
// Description: AHB-Lite GPIO slave. Provides atomic set/clear/toggle of the
//              outputs and per-bit edge-capture interrupts on synchronized
//              inputs. Optional input debounce is enabled by GPIO_DEBOUNCE_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module mfp_ahb_gpio_irq #(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [5:0]       HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [31:0]      HWDATA,
    input  logic             HWRITE,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    input  logic [N_IN-1:0]  GPIO_IN,
    output logic [N_OUT-1:0] GPIO_OUT,
    output logic             IRQ
);

    localparam logic [1:0] C_HTRANS_IDLE = 2'b00;
    localparam logic [3:0] C_IDX_IN      = 4'd0;
    localparam logic [3:0] C_IDX_OUT     = 4'd1;
    localparam logic [3:0] C_IDX_SET     = 4'd2;
    localparam logic [3:0] C_IDX_CLR     = 4'd3;
    localparam logic [3:0] C_IDX_TGL     = 4'd4;
    localparam logic [3:0] C_IDX_RISE    = 4'd5;
    localparam logic [3:0] C_IDX_FALL    = 4'd6;
    localparam logic [3:0] C_IDX_STATUS  = 4'd7;
    localparam logic [3:0] C_IDX_MASK    = 4'd8;

    logic [3:0]       idx_q;
    logic             hsel_q;
    logic             hwrite_q;
    logic [1:0]       htrans_q;

    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  rise_q, rise_d;
    logic [N_IN-1:0]  fall_q, fall_d;
    logic [N_IN-1:0]  status_q, status_d;
    logic [N_IN-1:0]  mask_q, mask_d;
    logic [N_IN-1:0]  sync1_q, sync2_q, prev_q;
    logic [31:0]      rdata_d;
    logic             irq_d;

    logic             w_wr_en;
    logic [N_OUT-1:0] w_wdata_out;
    logic [N_IN-1:0]  w_wdata_in;
    logic [N_IN-1:0]  w_in;
    logic [N_IN-1:0]  w_edge;
    logic [N_IN-1:0]  w_w1c;

    // Address/data bits outside the register map and widths are don't-care.
    logic unused_bits;
    assign unused_bits = ^{HADDR[1:0], HWDATA, DB_CYCLES[7:0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q    <= '0;
            hsel_q   <= 1'b0;
            hwrite_q <= 1'b0;
            htrans_q <= C_HTRANS_IDLE;
        end else begin
            idx_q    <= HADDR[5:2];
            hsel_q   <= HSEL;
            hwrite_q <= HWRITE;
            htrans_q <= HTRANS;
        end
    end

    assign w_wr_en     = hsel_q & hwrite_q & (htrans_q != C_HTRANS_IDLE);
    assign w_wdata_out = HWDATA[N_OUT-1:0];
    assign w_wdata_in  = HWDATA[N_IN-1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= GPIO_IN;
            sync2_q <= sync1_q;
            prev_q  <= w_in;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] C_DB_LAST = 8'(DB_CYCLES - 1);

    // A bit only flips after the synchronized level has disagreed with it
    // for DB_CYCLES consecutive clocks; any agreement restarts the count.
    for (genvar i = 0; i < N_IN; i++) begin : g_db
        logic [7:0] cnt_q;
        logic       in_q;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                cnt_q <= '0;
                in_q  <= 1'b0;
            end else if (sync2_q[i] == in_q) begin
                cnt_q <= '0;
            end else if (cnt_q == C_DB_LAST) begin
                cnt_q <= '0;
                in_q  <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign w_in[i] = in_q;
    end
`else
    assign w_in = sync2_q;
`endif

    assign w_edge = (w_in & ~prev_q & rise_q) | (~w_in & prev_q & fall_q);

    always_comb begin
        out_d  = out_q;
        rise_d = rise_q;
        fall_d = fall_q;
        mask_d = mask_q;
        w_w1c  = '0;
        if (w_wr_en) begin
            case (idx_q)
                C_IDX_OUT:    out_d  = w_wdata_out;
                C_IDX_SET:    out_d  = out_q | w_wdata_out;
                C_IDX_CLR:    out_d  = out_q & ~w_wdata_out;
                C_IDX_TGL:    out_d  = out_q ^ w_wdata_out;
                C_IDX_RISE:   rise_d = w_wdata_in;
                C_IDX_FALL:   fall_d = w_wdata_in;
                C_IDX_STATUS: w_w1c  = w_wdata_in;
                C_IDX_MASK:   mask_d = w_wdata_in;
                default:      ;
            endcase
        end
        // New edges win over a simultaneous clear so no event is lost.
        status_d = (status_q & ~w_w1c) | w_edge;
        irq_d    = |(status_q & mask_q);
    end

    always_comb begin
        rdata_d = '0;
        case (HADDR[5:2])
            C_IDX_IN:     rdata_d[N_IN-1:0]  = w_in;
            C_IDX_OUT:    rdata_d[N_OUT-1:0] = out_q;
            C_IDX_RISE:   rdata_d[N_IN-1:0]  = rise_q;
            C_IDX_FALL:   rdata_d[N_IN-1:0]  = fall_q;
            C_IDX_STATUS: rdata_d[N_IN-1:0]  = status_q;
            C_IDX_MASK:   rdata_d[N_IN-1:0]  = mask_q;
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            out_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            HRDATA   <= '0;
            IRQ      <= 1'b0;
        end else begin
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            HRDATA   <= rdata_d;
            IRQ      <= irq_d;
        end
    end

    assign GPIO_OUT = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module     : tb_mfp_ahb_gpio_irq
// Description: Directed self-checking bench for the AHB GPIO/IRQ slave.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_gpio_irq;

`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [5:0]  HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic [15:0] GPIO_IN;
    logic [15:0] GPIO_OUT;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    mfp_ahb_gpio_irq #(
        .N_IN      (16),
        .N_OUT     (16),
        .DB_CYCLES (4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWDATA   (HWDATA),
        .HWRITE   (HWRITE),
        .HSEL     (HSEL),
        .HRDATA   (HRDATA),
        .GPIO_IN  (GPIO_IN),
        .GPIO_OUT (GPIO_OUT),
        .IRQ      (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Starts just after a clock edge; returns just after the write has landed.
    task automatic ahb_write(input logic [3:0] idx, input logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = {idx, 2'b00};
        tick(1);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = data;
        tick(1);
    endtask

    task automatic ahb_read(input logic [3:0] idx, output logic [31:0] d);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = {idx, 2'b00};
        tick(1);
        d      = HRDATA;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    logic [31:0] rd;

    initial begin
        HRESET  = 1'b1;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWDATA  = '0;
        HWRITE  = 1'b0;
        HSEL    = 1'b0;
        GPIO_IN = 16'hFFFF;

        // Reset
        tick(2);
        chk("rst_gpio_out", {16'h0, GPIO_OUT}, 32'h0);
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        HRESET = 1'b0;
        tick(6 + LAT);
        ahb_read(4'd0, rd);
        chk("in_all_high", rd, 32'h0000FFFF);
        ahb_read(4'd7, rd);
        chk("rst_status", rd, 32'h0);
        GPIO_IN = 16'h0000;
        tick(6 + LAT);
        ahb_read(4'd7, rd);
        chk("status_no_en", rd, 32'h0);

        // Atomic output operations
        ahb_write(4'd1, 32'hFFFF_00F0);
        chk("out_upper_ignored", {16'h0, GPIO_OUT}, 32'h000000F0);
        ahb_write(4'd2, 32'h0000_0003);
        chk("out_set", {16'h0, GPIO_OUT}, 32'h000000F3);
        ahb_write(4'd3, 32'h0000_0010);
        chk("out_clr", {16'h0, GPIO_OUT}, 32'h000000E3);
        ahb_write(4'd4, 32'h0000_8000);
        chk("out_tgl", {16'h0, GPIO_OUT}, 32'h000080E3);
        ahb_read(4'd1, rd);
        chk("rd_out", rd, 32'h000080E3);
        ahb_read(4'd2, rd);
        chk("rd_out_set", rd, 32'h0);

        // Rising-edge interrupt with exact latency
        ahb_write(4'd5, 32'h1);
        ahb_write(4'd8, 32'h1);
        GPIO_IN[0] = 1'b1;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = {4'd7, 2'b00};
        tick(3 + LAT);
        chk("rise_status_k2", HRDATA, 32'h0);
        chk("rise_irq_k2", {31'h0, IRQ}, 32'h0);
        tick(1);
        chk("rise_status_k3", HRDATA, 32'h1);
        chk("rise_irq_k3", {31'h0, IRQ}, 32'h1);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        ahb_write(4'd7, 32'h1);
        chk("w1c_irq_same", {31'h0, IRQ}, 32'h1);
        tick(1);
        chk("w1c_irq_next", {31'h0, IRQ}, 32'h0);
        ahb_read(4'd7, rd);
        chk("w1c_status", rd, 32'h0);

        // W1C colliding with a new falling edge on bit 1
        ahb_write(4'd6, 32'h2);
        GPIO_IN[1] = 1'b1;
        tick(6 + LAT);
        ahb_read(4'd7, rd);
        chk("fall_no_rise_cap", rd, 32'h0);
        GPIO_IN[1] = 1'b0;
        tick(1 + LAT);
        ahb_write(4'd7, 32'h2);
        ahb_read(4'd7, rd);
        chk("collision_status", rd, 32'h2);
        chk("collision_irq_masked", {31'h0, IRQ}, 32'h0);
        ahb_write(4'd7, 32'h2);
        ahb_read(4'd7, rd);
        chk("fall_cleared", rd, 32'h0);

        // Polled mode, late unmask, register holes
        ahb_write(4'd8, 32'h0);
        GPIO_IN[0] = 1'b0;
        tick(6 + LAT);
        GPIO_IN[0] = 1'b1;
        tick(6 + LAT);
        ahb_read(4'd7, rd);
        chk("poll_status", rd, 32'h1);
        chk("poll_irq", {31'h0, IRQ}, 32'h0);
        ahb_write(4'd8, 32'h1);
        tick(1);
        chk("unmask_irq", {31'h0, IRQ}, 32'h1);
        ahb_write(4'd5, 32'h0);
        ahb_read(4'd7, rd);
        chk("en_change_keeps", rd, 32'h1);
        ahb_read(4'd5, rd);
        chk("rd_rise_en", rd, 32'h0);
        ahb_read(4'd6, rd);
        chk("rd_fall_en", rd, 32'h2);
        ahb_read(4'd8, rd);
        chk("rd_mask", rd, 32'h1);
        ahb_write(4'd12, 32'hFFFF_FFFF);
        ahb_read(4'd12, rd);
        chk("rd_hole", rd, 32'h0);
        ahb_read(4'd1, rd);
        chk("hole_wr_ignored", rd, 32'h000080E3);
        ahb_write(4'd7, 32'hFFFF);
        tick(1);
        chk("irq_final_clear", {31'h0, IRQ}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: a 3-cycle glitch is rejected, a long level is accepted
        ahb_write(4'd5, 32'h2);
        GPIO_IN[1] = 1'b1;
        tick(3);
        GPIO_IN[1] = 1'b0;
        tick(12);
        ahb_read(4'd0, rd);
        chk("db_glitch_in", rd, 32'h1);
        ahb_read(4'd7, rd);
        chk("db_glitch_status", rd, 32'h0);
        GPIO_IN[1] = 1'b1;
        tick(12);
        ahb_read(4'd0, rd);
        chk("db_level_in", rd, 32'h3);
        ahb_read(4'd7, rd);
        chk("db_level_status", rd, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
